dmem_req_ctrl: RTL and testbench
================================

Name: dmem_req_ctrl

Overview:
- Memory-stage request controller between the execute stage and the data memory port.
- Accepts one load or store per handshake:
  - Stores arrive with data already lane-aligned.
  - Computes the word address and byte write mask, and checks alignment.
  - Drives a valid/ready request to data memory.
- For loads, captures the raw 32-bit memory word and holds it, with funct and byte offset, for the downstream load-extend logic.
- Stalls the pipeline while an access is outstanding.

Parameters:
- DATA_W, 32, data word width (fixed 32; byte mask is DATA_W/8 = 4 bits)
- TIMEOUT, 255, WAIT-state watchdog limit in cycles (used only with DMEM_TIMEOUT_EN)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execute stage presents a memory op
- req_ready  output  1  controller accepts the op this cycle
- req_opcode  input  7  OPC_LOAD / OPC_STORE; any other value is a no-op
- req_funct  input  3  FNC_LB/LH/LW/LBU/LHU or FNC_SB/SH/SW
- req_addr  input  32  byte address
- req_wdata  input  32  lane-aligned store data
- req_rd  input  5  destination register tag (loads)
- mem_req_valid  output  1  request to data memory
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  32  {req_addr[31:2],2'b00}
- mem_wdata  output  32  registered req_wdata
- mem_we  output  4  byte write mask; 0 for loads
- mem_re  output  1  read strobe, 1 for loads
- mem_resp_valid  input  1  load data returned, one-cycle pulse
- mem_resp_data  input  32  raw memory word
- rsp_valid  output  1  load result held for downstream
- rsp_ready  input  1  downstream consumes result
- rsp_data  output  32  raw word
- rsp_funct  output  3  captured funct
- rsp_offset  output  2  captured req_addr[1:0]
- rsp_rd  output  5  captured tag
- rsp_err  output  1  result is a timeout error (0 unless DMEM_TIMEOUT_EN)
- misalign  output  1  one-cycle pulse: op rejected (misaligned or illegal funct)
- stall  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - All captured registers clear.
  - An access in flight is abandoned; a late mem_resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid:
  - Opcode is neither LOAD nor STORE: accept and drop; stay IDLE; no pulse.
  - Misaligned or illegal funct: accept and drop; misalign=1 for the next cycle; stay IDLE.
  - Otherwise: register addr, wdata, funct, offset, rd and mask; go to REQ.
- Alignment and mask, with off = addr[1:0]:
  - B: any off; mask 4'b0001<<off.
  - H: off 0,1,2 legal, 3 misaligned; mask 4'b0011<<off.
  - W: off 0 only; mask 4'b1111.
- REQ: mem_req_valid=1 with address and controls held stable until mem_req_ready.
  - On handshake, a store goes to IDLE (posted; no rsp).
  - On handshake, a load goes to WAIT.
- WAIT: mem_req_valid=0.
  - On mem_resp_valid: capture mem_resp_data into rsp_data; go to RESP.
  - A response arriving in the same cycle as the handshake is not possible; memory latency is at least 1 cycle.
- RESP: rsp_valid=1, outputs stable.
  - On rsp_ready: go to IDLE.
  - req_ready stays 0 until IDLE.
- Throughput:
  - Store: minimum 2 cycles from accept to next accept.
  - Load: minimum 4 cycles.
- stall=1 in REQ, WAIT, RESP.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- With the macro:
  - An 8-bit (log2(TIMEOUT+1)) counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without a response: go to RESP with rsp_data=32'hDEADBEEF, rsp_err=1.
  - If the response and the limit coincide, the response wins, with rsp_err=0.
- Without the macro: no counter; WAIT waits indefinitely; rsp_err is tied to 0.

Test Plan:
- SB, addr 0x1003, wdata 0xAB000000, mem_req_ready=1 -> mem_addr 0x1000, mem_we 4'b1000, mem_wdata 0xAB000000; back to IDLE 2 cycles after accept.
- LH addr 0x2002, memory returns 0x8001_1234 after 3 cycles -> rsp_valid, rsp_data 0x80011234, rsp_funct FNC_LH, rsp_offset 2; held until rsp_ready, then req_ready=1.
- LW addr 0x3001 -> misalign pulse 1 cycle, no mem_req_valid, state IDLE; SH addr 0x3003 -> same.
- Store with mem_req_ready held 0 for 5 cycles -> mem_req_valid, mem_addr, mem_we stable all 5 cycles; stall=1.
- Load in WAIT, rst_n pulsed low, then mem_resp_valid -> all outputs 0, req_ready=1, response ignored, rsp_valid stays 0.
- DMEM_TIMEOUT_EN defined, TIMEOUT=8, no response -> rsp_valid after 8 WAIT cycles with rsp_data 0xDEADBEEF, rsp_err=1.

Source files
------------

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl
// Memory-stage request controller. It sits between the execute stage and the
// data memory port and takes one load or store per req_valid/req_ready
// handshake. Store data arrives already lane-aligned. For each op it checks
// alignment, builds the word address and the byte write mask, and issues a
// valid/ready request to data memory. A load response is captured and held
// on rsp_* (raw word, funct, byte offset, rd tag) until the downstream
// load-extend logic takes it. stall is high while any access is in flight.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           op handshake from the execute stage
//   req_opcode/funct/addr/wdata/rd  op fields
//   mem_req_valid/mem_req_ready   request handshake to data memory
//   mem_addr/mem_wdata/mem_we/mem_re  request fields (word address, data,
//                                 byte mask, read strobe)
//   mem_resp_valid/mem_resp_data  one-cycle load return from memory
//   rsp_valid/rsp_ready           held load result to downstream
//   rsp_data/funct/offset/rd/err  load result fields
//   misalign                      one-cycle pulse when an op is rejected
//   stall                         controller is busy (state != IDLE)
//
// Build option:
//   DMEM_TIMEOUT_EN  adds a WAIT-state watchdog. If no response arrives
//                    within TIMEOUT cycles, the result is 32'hDEADBEEF with
//                    rsp_err=1. Without this macro, WAIT has no time limit
//                    and rsp_err is always 0.
//
// state | meaning
// IDLE  | ready for a new op
// REQ   | request presented to memory, waiting for mem_req_ready
// WAIT  | load accepted by memory, waiting for mem_resp_valid
// RESP  | load result held on rsp_*, waiting for rsp_ready

module dmem_req_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [6:0]          req_opcode,
    input  logic [2:0]          req_funct,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_rd,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_we,
    output logic                mem_re,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [2:0]          rsp_funct,
    output logic [1:0]          rsp_offset,
    output logic [4:0]          rsp_rd,
    output logic                rsp_err,
    output logic                misalign,
    output logic                stall
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]          state;
    logic [1:0]          off;
    logic                is_load;
    logic                is_store;
    logic                legal;
    logic [DATA_W/8-1:0] lane_mask;

    assign off      = req_addr[1:0];
    assign is_load  = (req_opcode == OPC_LOAD);
    assign is_store = (req_opcode == OPC_STORE);

    // Byte, half and word accesses share the same alignment rules for loads
    // and stores. A halfword at offset 1 is legal because it stays inside
    // one word. Only the lane_mask of a store reaches mem_we.
    always_comb begin
        legal     = 1'b0;
        lane_mask = '0;
        if (is_load) begin
            case (req_funct)
                FNC_LB, FNC_LBU: begin
                    legal     = 1'b1;
                    lane_mask = 4'b0001 << off;
                end
                FNC_LH, FNC_LHU: begin
                    legal     = (off != 2'd3);
                    lane_mask = 4'b0011 << off;
                end
                FNC_LW: begin
                    legal     = (off == 2'd0);
                    lane_mask = 4'b1111;
                end
                default: legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (req_funct)
                FNC_SB: begin
                    legal     = 1'b1;
                    lane_mask = 4'b0001 << off;
                end
                FNC_SH: begin
                    legal     = (off != 2'd3);
                    lane_mask = 4'b0011 << off;
                end
                FNC_SW: begin
                    legal     = (off == 2'd0);
                    lane_mask = 4'b1111;
                end
                default: legal = 1'b0;
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= '0;
            mem_re     <= 1'b0;
            rsp_data   <= '0;
            rsp_funct  <= '0;
            rsp_offset <= '0;
            rsp_rd     <= '0;
            misalign   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    // Ops whose opcode is neither load nor store are accepted
                    // and dropped without any pulse.
                    if (req_valid && (is_load || is_store)) begin
                        if (!legal) begin
                            misalign <= 1'b1;
                        end else begin
                            mem_addr   <= {req_addr[31:2], 2'b00};
                            mem_wdata  <= req_wdata;
                            mem_we     <= is_store ? lane_mask : '0;
                            mem_re     <= is_load;
                            rsp_funct  <= req_funct;
                            rsp_offset <= off;
                            rsp_rd     <= req_rd;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        // Stores are posted and produce no response.
                        state <= mem_re ? WAIT : IDLE;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    // A real response wins over the watchdog if both happen
                    // in the same cycle.
                    if (mem_resp_valid) begin
                        rsp_data <= mem_resp_data;
                        state    <= RESP;
`ifdef DMEM_TIMEOUT_EN
                        err_q    <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data <= 32'hDEADBEEF;
                        err_q    <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
`ifdef DMEM_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign rsp_valid     = (state == RESP);
    assign stall         = (state != IDLE);

`ifdef DMEM_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
module tb_dmem_req_ctrl;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_funct;
    logic [1:0]  rsp_offset;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        misalign;
    logic        stall;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_req_ctrl #(.DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_funct(rsp_funct),
        .rsp_offset(rsp_offset), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .misalign(misalign), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge. Outputs are sampled and inputs changed
    // 1ns later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [6:0] opc, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd);
        req_valid  = 1'b1;
        req_opcode = opc;
        req_funct  = fn;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_opcode = '0; req_funct = '0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; rsp_ready = 1'b0;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // SB at offset 3: byte lane 3
        mem_req_ready = 1'b1;
        drive_op(OPC_STORE, 3'b000, 32'h0000_1003, 32'hAB00_0000, 5'd0);
        chk("sb_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("sb_mem_addr", mem_addr, 32'h0000_1000);
        chk("sb_mem_we", {28'd0, mem_we}, 32'h8);
        chk("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
        chk("sb_mem_re", {31'd0, mem_re}, 32'd0);
        chk("sb_stall", {31'd0, stall}, 32'd1);
        chk("sb_req_ready_busy", {31'd0, req_ready}, 32'd0);
        tick();
        chk("sb_back_idle", {31'd0, req_ready}, 32'd1);
        chk("sb_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // SH at offset 2: lanes 3..2
        drive_op(OPC_STORE, 3'b001, 32'h0000_5002, 32'hBEEF_0000, 5'd0);
        chk("sh_mem_we", {28'd0, mem_we}, 32'hC);
        tick();

        // LH at offset 2, response after three cycles
        drive_op(OPC_LOAD, 3'b001, 32'h0000_2002, 32'h0, 5'd7);
        chk("lh_mem_re", {31'd0, mem_re}, 32'd1);
        chk("lh_mem_we", {28'd0, mem_we}, 32'h0);
        chk("lh_mem_addr", mem_addr, 32'h0000_2000);
        tick();
        mem_req_ready = 1'b0;
        chk("lh_wait_no_req", {31'd0, mem_req_valid}, 32'd0);
        chk("lh_wait_stall", {31'd0, stall}, 32'd1);
        tick();
        tick();
        chk("lh_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h8001_1234;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        chk("lh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lh_rsp_data", rsp_data, 32'h8001_1234);
        chk("lh_rsp_funct", {29'd0, rsp_funct}, 32'd1);
        chk("lh_rsp_offset", {30'd0, rsp_offset}, 32'd2);
        chk("lh_rsp_rd", {27'd0, rsp_rd}, 32'd7);
        chk("lh_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("lh_req_ready_busy", {31'd0, req_ready}, 32'd0);
        tick();
        chk("lh_rsp_held", {31'd0, rsp_valid}, 32'd1);
        chk("lh_rsp_data_held", rsp_data, 32'h8001_1234);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("lh_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("lh_idle_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Rejected ops: misaligned LW, misaligned SH, illegal load funct
        drive_op(OPC_LOAD, 3'b010, 32'h0000_3001, 32'h0, 5'd1);
        chk("lw_mis_pulse", {31'd0, misalign}, 32'd1);
        chk("lw_mis_no_req", {31'd0, mem_req_valid}, 32'd0);
        chk("lw_mis_idle", {31'd0, req_ready}, 32'd1);
        tick();
        chk("lw_mis_one_cycle", {31'd0, misalign}, 32'd0);
        drive_op(OPC_STORE, 3'b001, 32'h0000_3003, 32'h0, 5'd0);
        chk("sh_mis_pulse", {31'd0, misalign}, 32'd1);
        chk("sh_mis_no_req", {31'd0, mem_req_valid}, 32'd0);
        tick();
        chk("sh_mis_one_cycle", {31'd0, misalign}, 32'd0);
        drive_op(OPC_LOAD, 3'b011, 32'h0000_3000, 32'h0, 5'd0);
        chk("ill_funct_pulse", {31'd0, misalign}, 32'd1);
        tick();
        // Non-memory opcode: dropped silently
        drive_op(OPC_ALU, 3'b010, 32'h0000_3001, 32'h0, 5'd0);
        chk("nop_no_pulse", {31'd0, misalign}, 32'd0);
        chk("nop_idle", {31'd0, stall}, 32'd0);

        // SW held off by memory for 5 cycles while inputs wander
        mem_req_ready = 1'b0;
        drive_op(OPC_STORE, 3'b010, 32'h0000_4004, 32'h1122_3344, 5'd0);
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_funct = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk("sw_hold_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("sw_hold_addr", mem_addr, 32'h0000_4004);
            chk("sw_hold_we", {28'd0, mem_we}, 32'hF);
            chk("sw_hold_wdata", mem_wdata, 32'h1122_3344);
            chk("sw_hold_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        chk("sw_done_idle", {31'd0, req_ready}, 32'd1);

        // Reset while a load is in WAIT, then a late response
        drive_op(OPC_LOAD, 3'b100, 32'h0000_6001, 32'h0, 5'd3);
        tick();
        mem_req_ready = 1'b0;
        chk("rst_wait_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_async_stall", {31'd0, stall}, 32'd0);
        chk("rst_async_addr", mem_addr, 32'd0);
        chk("rst_async_re", {31'd0, mem_re}, 32'd0);
        chk("rst_async_rd", {27'd0, rsp_rd}, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0055;
        tick();
        mem_resp_valid = 1'b0;
        chk("late_rsp_ignored", {31'd0, rsp_valid}, 32'd0);
        chk("late_rsp_data", rsp_data, 32'd0);
        tick();
        chk("late_rsp_idle", {31'd0, stall}, 32'd0);

        // Load with no response
        mem_req_ready = 1'b1;
        drive_op(OPC_LOAD, 3'b010, 32'h0000_7000, 32'h0, 5'd9);
        tick();
        mem_req_ready = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        tick();
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_idle", {31'd0, req_ready}, 32'd1);
        chk("to_err_clear", {31'd0, rsp_err}, 32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nto_still_wait", {31'd0, stall}, 32'd1);
        chk("nto_no_rsp", {31'd0, rsp_valid}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1357_9BDF;
        tick();
        mem_resp_valid = 1'b0;
        chk("nto_rsp_data", rsp_data, 32'h1357_9BDF);
        chk("nto_rsp_err", {31'd0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("nto_idle", {31'd0, req_ready}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
